// File: rtl/stream_eos_sink.sv
// Stream sink: starts a circuit through its control handshake, then consumes CHANNELS
// {field0, EOS} streams while keeping per-channel counts and wrap-around sums.
module stream_eos_sink #(
    parameter int          DATA_WIDTH     = 64,
    parameter int          CHANNELS       = 1,
    parameter int          CNT_WIDTH      = 32,
    parameter int          READY_MODE     = 0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic                           clock,
    input  logic                           reset,
    output logic                           inCtrl_valid,
    input  logic                           inCtrl_ready,
    input  logic                           outCtrl_valid,
    output logic                           outCtrl_ready,
    input  logic [CHANNELS-1:0]            in_valid,
    output logic [CHANNELS-1:0]            in_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0] in_data_field0,
    input  logic [CHANNELS-1:0]            in_data_field1,
    output logic [CHANNELS*CNT_WIDTH-1:0]  count,
    output logic [CHANNELS*DATA_WIDTH-1:0] sum,
    output logic [CHANNELS-1:0]            eos_seen,
    output logic                           done,
    output logic [1:0]                     error
);

    typedef enum logic [2:0] {S_RESET, S_START, S_RUN, S_DONE, S_FAIL} state_t;

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    state_t                state_reg;
    logic [15:0]           lfsr_reg;
    logic [15:0]           lfsr_next;
    logic [WD_W-1:0]       wd_reg;
    logic [WD_W-1:0]       wd_next;
    logic                  ctrl_seen_reg;
    logic                  ctrl_seen_next;
    logic [CHANNELS-1:0]   eos_reg;
    logic [CHANNELS-1:0]   eos_next;
    logic [1:0]            error_reg;
    logic [CNT_WIDTH-1:0]  count_reg [CHANNELS];
    logic [DATA_WIDTH-1:0] sum_reg   [CHANNELS];

    logic [CHANNELS-1:0]   ready_pattern;
    logic [CHANNELS-1:0]   xfer;
    logic [CHANNELS-1:0]   post_hit;
    logic [CHANNELS-1:0]   eos_hit;
    logic [CHANNELS-1:0]   data_hit;
    logic                  ctrl_xfer;
    logic                  any_xfer;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            if (READY_MODE == 1) begin : g_lfsr_ready
                assign ready_pattern[gi] = lfsr_reg[gi % 16];
            end else begin : g_always_ready
                assign ready_pattern[gi] = 1'b1;
            end
            assign xfer[gi]     = in_valid[gi] & in_ready[gi];
            // Anything arriving after EOS is a protocol violation and leaves the counters alone.
            assign post_hit[gi] = xfer[gi] & eos_reg[gi];
            assign eos_hit[gi]  = xfer[gi] & ~eos_reg[gi] & in_data_field1[gi];
            assign data_hit[gi] = xfer[gi] & ~eos_reg[gi] & ~in_data_field1[gi];
            assign count[gi*CNT_WIDTH +: CNT_WIDTH]   = count_reg[gi];
            assign sum[gi*DATA_WIDTH +: DATA_WIDTH]   = sum_reg[gi];
        end
    endgenerate

    always_comb begin
        in_ready = '0;
        case (state_reg)
            S_RUN:   in_ready = ready_pattern;
            S_DONE:  in_ready = '1;
            default: in_ready = '0;
        endcase
    end

    assign inCtrl_valid   = (state_reg == S_START);
    assign outCtrl_ready  = (state_reg == S_RUN) & ~ctrl_seen_reg;
    assign done           = (state_reg == S_DONE);
    assign eos_seen       = eos_reg;
    assign error          = error_reg;

    assign ctrl_xfer      = outCtrl_valid & outCtrl_ready;
    assign any_xfer       = (|xfer) | ctrl_xfer;
    assign eos_next       = eos_reg | eos_hit;
    assign ctrl_seen_next = ctrl_seen_reg | ctrl_xfer;
    assign wd_next        = wd_reg + WD_W'(1);
    // Fibonacci taps 16,14,13,11 with the feedback entering bit 0.
    assign lfsr_next      = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= S_RESET;
            lfsr_reg      <= LFSR_SEED;
            wd_reg        <= '0;
            ctrl_seen_reg <= 1'b0;
            eos_reg       <= '0;
            error_reg     <= 2'b00;
            for (int i = 0; i < CHANNELS; i++) begin
                count_reg[i] <= '0;
                sum_reg[i]   <= '0;
            end
        end else begin
            case (state_reg)
                S_RESET: state_reg <= S_START;
                S_START: begin
                    wd_reg <= '0;
                    if (inCtrl_ready) state_reg <= S_RUN;
                end
                S_RUN: begin
                    lfsr_reg      <= lfsr_next;
                    ctrl_seen_reg <= ctrl_seen_next;
                    eos_reg       <= eos_next;
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (data_hit[i]) begin
                            if (count_reg[i] != '1) count_reg[i] <= count_reg[i] + CNT_WIDTH'(1);
                            sum_reg[i] <= sum_reg[i] + in_data_field0[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if (|post_hit) begin
                        error_reg[1] <= 1'b1;
                        state_reg    <= S_FAIL;
                    end else if ((&eos_next) && ctrl_seen_next) begin
                        state_reg <= S_DONE;
                    end else if (any_xfer) begin
                        wd_reg <= '0;
                    end else if ((TIMEOUT_CYCLES != 0) && (wd_next == WD_LIMIT)) begin
                        error_reg[0] <= 1'b1;
                        state_reg    <= S_FAIL;
                    end else begin
                        wd_reg <= wd_next;
                    end
                end
                S_DONE: begin
                    if (|xfer) begin
                        error_reg[1] <= 1'b1;
                        state_reg    <= S_FAIL;
                    end
                end
                default: state_reg <= S_FAIL;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_eos_sink.sv
// Directed bench for stream_eos_sink: three instances cover the basic, LFSR-backpressure,
// narrow-wrap/two-channel, timeout and mid-run reset scenarios.
module tb_stream_eos_sink;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // Instance A: one 64-bit channel, always ready, 16-cycle watchdog
    logic        a_rst, a_ictl_v, a_ictl_r, a_octl_v, a_octl_r;
    logic [0:0]  a_v, a_r, a_d1, a_eos;
    logic [63:0] a_d0, a_sum;
    logic [31:0] a_count;
    logic        a_done;
    logic [1:0]  a_err;

    stream_eos_sink #(.DATA_WIDTH(64), .CHANNELS(1), .CNT_WIDTH(32), .READY_MODE(0),
                      .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(16)) dut_a (
        .clock(clk), .reset(a_rst),
        .inCtrl_valid(a_ictl_v), .inCtrl_ready(a_ictl_r),
        .outCtrl_valid(a_octl_v), .outCtrl_ready(a_octl_r),
        .in_valid(a_v), .in_ready(a_r), .in_data_field0(a_d0), .in_data_field1(a_d1),
        .count(a_count), .sum(a_sum), .eos_seen(a_eos), .done(a_done), .error(a_err));

    // Instance B: one 16-bit channel, LFSR-gated ready
    logic        b_rst, b_ictl_v, b_ictl_r, b_octl_v, b_octl_r;
    logic [0:0]  b_v, b_r, b_d1, b_eos;
    logic [15:0] b_d0, b_sum;
    logic [31:0] b_count;
    logic        b_done;
    logic [1:0]  b_err;

    stream_eos_sink #(.DATA_WIDTH(16), .CHANNELS(1), .CNT_WIDTH(32), .READY_MODE(1),
                      .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(1024)) dut_b (
        .clock(clk), .reset(b_rst),
        .inCtrl_valid(b_ictl_v), .inCtrl_ready(b_ictl_r),
        .outCtrl_valid(b_octl_v), .outCtrl_ready(b_octl_r),
        .in_valid(b_v), .in_ready(b_r), .in_data_field0(b_d0), .in_data_field1(b_d1),
        .count(b_count), .sum(b_sum), .eos_seen(b_eos), .done(b_done), .error(b_err));

    // Instance C: two 8-bit channels, always ready
    logic        c_rst, c_ictl_v, c_ictl_r, c_octl_v, c_octl_r;
    logic [1:0]  c_v, c_r, c_d1, c_eos;
    logic [15:0] c_d0, c_sum;
    logic [63:0] c_count;
    logic        c_done;
    logic [1:0]  c_err;

    stream_eos_sink #(.DATA_WIDTH(8), .CHANNELS(2), .CNT_WIDTH(32), .READY_MODE(0),
                      .LFSR_SEED(16'hACE1), .TIMEOUT_CYCLES(1024)) dut_c (
        .clock(clk), .reset(c_rst),
        .inCtrl_valid(c_ictl_v), .inCtrl_ready(c_ictl_r),
        .outCtrl_valid(c_octl_v), .outCtrl_ready(c_octl_r),
        .in_valid(c_v), .in_ready(c_r), .in_data_field0(c_d0), .in_data_field1(c_d1),
        .count(c_count), .sum(c_sum), .eos_seen(c_eos), .done(c_done), .error(c_err));

    task automatic a_start();
        a_rst = 1'b0; tick();
        a_rst = 1'b1; tick();
        a_ictl_r = 1'b1; tick();
        a_ictl_r = 1'b0;
    endtask

    task automatic c_start();
        c_rst = 1'b0; tick();
        c_rst = 1'b1; tick();
        c_ictl_r = 1'b1; tick();
        c_ictl_r = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [15:0] m;
        int          val;
        int          guard;
        logic        rdy;

        a_rst = 0; a_ictl_r = 0; a_octl_v = 0; a_v = 0; a_d0 = 0; a_d1 = 0;
        b_rst = 0; b_ictl_r = 0; b_octl_v = 0; b_v = 0; b_d0 = 0; b_d1 = 0;
        c_rst = 0; c_ictl_r = 0; c_octl_v = 0; c_v = 0; c_d0 = 0; c_d1 = 0;
        tick(); tick();

        // Reset state
        check("rst_ictl_v", a_ictl_v, 0);
        check("rst_in_ready", a_r, 0);
        check("rst_octl_r", a_octl_r, 0);
        check("rst_count", a_count, 0);
        check("rst_done", a_done, 0);
        check("rst_error", a_err, 0);

        // Basic: 5,7,9, EOS, then outCtrl
        a_rst = 1'b1; tick();
        check("start_ictl_v", a_ictl_v, 1);
        check("start_in_ready", a_r, 0);
        a_ictl_r = 1'b1; tick(); a_ictl_r = 1'b0;
        check("run_ictl_v", a_ictl_v, 0);
        check("run_octl_r", a_octl_r, 1);
        check("run_in_ready", a_r, 1);
        a_v = 1; a_d0 = 64'd5; tick();
        a_d0 = 64'd7; tick();
        a_d0 = 64'd9; tick();
        check("basic_count3", a_count, 3);
        check("basic_sum21", a_sum, 21);
        a_d1 = 1; a_d0 = 64'd123; tick();
        a_v = 0; a_d1 = 0;
        check("basic_eos", a_eos, 1);
        check("basic_no_done_yet", a_done, 0);
        check("basic_sum_eos_ignored", a_sum, 21);
        a_octl_v = 1; tick(); a_octl_v = 0;
        check("basic_done", a_done, 1);
        check("basic_err", a_err, 0);
        check("basic_count_final", a_count, 3);
        check("done_in_ready", a_r, 1);
        check("done_octl_r", a_octl_r, 0);
        // Beat after done
        a_v = 1; a_d0 = 64'd1; tick(); a_v = 0;
        check("postdone_err", a_err, 2'b10);
        check("postdone_done", a_done, 0);
        check("postdone_count", a_count, 3);
        check("fail_in_ready", a_r, 0);

        // Watchdog: 16 idle cycles after RUN entry
        a_start();
        check("wd_cleared_err", a_err, 0);
        check("wd_cleared_count", a_count, 0);
        for (int i = 0; i < 15; i++) tick();
        check("wd_err_before", a_err, 0);
        check("wd_octl_r_before", a_octl_r, 1);
        tick();
        check("wd_err", a_err, 2'b01);
        check("wd_fail_in_ready", a_r, 0);
        check("wd_fail_octl_r", a_octl_r, 0);
        check("wd_done", a_done, 0);

        // Reset in the middle of RUN
        a_start();
        a_v = 1; a_d0 = 64'd10; tick();
        a_d0 = 64'd20; tick();
        a_d1 = 1; tick();
        a_v = 0; a_d1 = 0;
        check("mid_count", a_count, 2);
        check("mid_sum", a_sum, 30);
        check("mid_eos", a_eos, 1);
        a_rst = 1'b0; tick();
        check("midrst_count", a_count, 0);
        check("midrst_sum", a_sum, 0);
        check("midrst_eos", a_eos, 0);
        check("midrst_err", a_err, 0);
        check("midrst_ictl_v", a_ictl_v, 0);
        a_rst = 1'b1; tick();
        check("midrst_ictl_v_back", a_ictl_v, 1);

        // LFSR-gated ready, values 1..100 held valid, outCtrl in the first RUN cycle
        b_rst = 1'b1; tick();
        b_ictl_r = 1'b1; tick(); b_ictl_r = 1'b0;
        m = 16'hACE1;
        val = 1;
        guard = 0;
        b_octl_v = 1;
        while (val <= 100 && guard < 2000) begin
            b_v = 1; b_d0 = 16'(val); b_d1 = 0;
            rdy = m[0];
            check("lfsr_ready", b_r, rdy);
            tick();
            b_octl_v = 0;
            if (rdy) val++;
            m = lfsr_step(m);
            guard++;
        end
        check("lfsr_guard", (guard < 2000), 1);
        rdy = 1'b0;
        while (!rdy && guard < 2000) begin
            b_v = 1; b_d1 = 1; b_d0 = 16'hFFFF;
            rdy = m[0];
            check("lfsr_ready_eos", b_r, rdy);
            tick();
            m = lfsr_step(m);
            guard++;
        end
        b_v = 0; b_d1 = 0;
        check("lfsr_guard_eos", (guard < 2000), 1);
        check("lfsr_count", b_count, 100);
        check("lfsr_sum", b_sum, 5050);
        check("lfsr_done", b_done, 1);
        check("lfsr_err", b_err, 0);

        // Two 8-bit channels: wrap on ch0, outCtrl 3 cycles before joint EOS
        c_rst = 1'b1; tick();
        c_ictl_r = 1'b1; tick(); c_ictl_r = 1'b0;
        c_octl_v = 1; c_v = 2'b11; c_d0 = {8'd3, 8'd200}; tick();
        c_octl_v = 0; c_d0 = {8'd4, 8'd100}; tick();
        c_v = 2'b00; tick();
        check("two_no_done", c_done, 0);
        check("wrap_sum0", c_sum[7:0], 44);
        check("wrap_count0", c_count[31:0], 2);
        c_v = 2'b11; c_d1 = 2'b11; c_d0 = 16'hFFFF; tick();
        c_v = 2'b00; c_d1 = 2'b00;
        check("two_done", c_done, 1);
        check("two_eos", c_eos, 2'b11);
        check("two_sum1", c_sum[15:8], 7);
        check("two_count1", c_count[63:32], 2);
        check("two_err", c_err, 0);

        // Post-EOS data on channel 0
        c_start();
        c_v = 2'b01; c_d1 = 2'b01; tick();
        c_d1 = 2'b00; c_d0 = 16'd5; tick();
        check("post_err", c_err, 2'b10);
        check("post_count0", c_count[31:0], 0);
        check("post_sum0", c_sum[7:0], 0);
        c_v = 2'b10; c_d1 = 2'b10; c_octl_v = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_done_never", c_done, 0);
        end
        c_v = 2'b00; c_d1 = 2'b00; c_octl_v = 0;
        check("post_err_final", c_err, 2'b10);
        check("post_eos", c_eos, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
